// File: rtl/ir_fetch_controller.sv
// Instruction fetch sequencer: two byte reads per 16-bit instruction (low byte, then high byte),
// owning the PC, the memory read handshake, a per-read timeout and the IR write strobes.
module ir_fetch_controller #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCLoadValue,
  input  logic              MemReady,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              IRWrite,
  output logic              IRLH,
  output logic [ADDR_W-1:0] PC,
  output logic              InstrValid,
  output logic              Busy,
  output logic              FetchError
);

  // Counter only needs to reach WAIT_MAX-1; the timeout fires on the next empty cycle.
  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_L = 2'd1,
    FETCH_H = 2'd2,
    VALID   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             fetching;

  assign fetching = (state == FETCH_L) || (state == FETCH_H);

  // Moore decode with MemReady gating; Stall and PCLoad suppress the write-side strobes.
  assign MemRead    = fetching && !Stall;
  assign MemAddr    = PC;
  assign IRWrite    = fetching && MemReady && !Stall && !PCLoad;
  assign IRLH       = (state == FETCH_H);
  assign InstrValid = (state == VALID) && !Stall && !PCLoad;
  assign Busy       = fetching;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= ADDR_W'(RESET_PC);
      wait_cnt   <= '0;
      FetchError <= 1'b0;
    end else if (PCLoad) begin
      // Flush: any half-written IR is abandoned and never reported valid.
      state      <= IDLE;
      PC         <= PCLoadValue;
      wait_cnt   <= '0;
      FetchError <= 1'b0;
    end else if (!Stall) begin
      case (state)
        IDLE: begin
          if (Start && !FetchError) state <= FETCH_L;
        end
        FETCH_L, FETCH_H: begin
          if (MemReady) begin
            PC       <= PC + ADDR_W'(1);
            wait_cnt <= '0;
            state    <= (state == FETCH_L) ? FETCH_H : VALID;
          end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
            // PC keeps pointing at the byte that never arrived.
            FetchError <= 1'b1;
            wait_cnt   <= '0;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        VALID: begin
          state <= Start ? FETCH_L : IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_controller.sv
// Bench for ir_fetch_controller: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the fetch sequence.
module tb_ir_fetch_controller;

  localparam int unsigned AW   = 16;
  localparam int unsigned WMAX = 15;

  logic          Clock = 1'b0;
  logic          Reset, Start, Stall, PCLoad, MemReady;
  logic [AW-1:0] PCLoadValue;
  logic          MemRead, IRWrite, IRLH, InstrValid, Busy, FetchError;
  logic [AW-1:0] MemAddr, PC;

  int total = 0;
  int bad   = 0;

  // Model: "fetching an instruction, bytes already received", "complete instruction pending"
  bit          m_fetch;
  int unsigned m_got;
  bit          m_done;
  int unsigned m_wait;
  bit          m_err;
  logic [15:0] m_pc;

  ir_fetch_controller #(.ADDR_W(AW), .RESET_PC(0), .WAIT_MAX(WMAX)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stall(Stall), .PCLoad(PCLoad),
    .PCLoadValue(PCLoadValue), .MemReady(MemReady), .MemRead(MemRead), .MemAddr(MemAddr),
    .IRWrite(IRWrite), .IRLH(IRLH), .PC(PC), .InstrValid(InstrValid), .Busy(Busy),
    .FetchError(FetchError)
  );

  always #5 Clock = ~Clock;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = 1'b0; m_got = 0; m_done = 1'b0; m_wait = 0; m_err = 1'b0; m_pc = 16'h0000;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    if (Reset) model_reset();
    else if (PCLoad) begin
      m_pc = PCLoadValue; m_fetch = 1'b0; m_done = 1'b0; m_wait = 0; m_err = 1'b0;
    end else if (!Stall) begin
      if (m_done) begin
        m_done = 1'b0; m_fetch = Start; m_got = 0;
      end else if (m_fetch) begin
        if (MemReady) begin
          m_pc = m_pc + 16'h0001;
          m_wait = 0;
          if (m_got == 0) m_got = 1;
          else begin m_fetch = 1'b0; m_done = 1'b1; end
        end else begin
          m_wait++;
          if (m_wait == WMAX) begin m_err = 1'b1; m_fetch = 1'b0; m_wait = 0; end
        end
      end else if (Start && !m_err) begin
        m_fetch = 1'b1; m_got = 0;
      end
    end
  endtask

  task automatic compare_model();
    logic rd, wr, lh, iv, bsy, er;
    logic [15:0] pc;
    if (Reset) begin
      rd = 1'b0; wr = 1'b0; lh = 1'b0; iv = 1'b0; bsy = 1'b0; er = 1'b0; pc = 16'h0000;
    end else begin
      bsy = m_fetch;
      lh  = m_fetch && (m_got == 1);
      rd  = m_fetch && !Stall;
      wr  = rd && MemReady && !PCLoad;
      iv  = m_done && !Stall && !PCLoad;
      er  = m_err;
      pc  = m_pc;
    end
    chk1("MemRead", MemRead, rd);
    chk1("IRWrite", IRWrite, wr);
    chk1("IRLH", IRLH, lh);
    chk1("InstrValid", InstrValid, iv);
    chk1("Busy", Busy, bsy);
    chk1("FetchError", FetchError, er);
    chk16("PC", PC, pc);
    chk16("MemAddr", MemAddr, pc);
  endtask

  // One cycle: compare mid-cycle, advance model at the edge, then return just after it.
  task automatic step();
    @(negedge Clock);
    compare_model();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0; PCLoad = 1'b0; MemReady = 1'b0;
    PCLoadValue = '0;
    step(); step();
    chk16("reset_pc", PC, 16'h0000);
    chk1("reset_memread", MemRead, 1'b0);
    Reset = 1'b0;

    // Back-to-back fetch from 0x0010 with memory always ready
    PCLoad = 1'b1; PCLoadValue = 16'h0010; step();
    PCLoad = 1'b0; Start = 1'b1; MemReady = 1'b1; step();
    chk1("t2_wr_lo", IRWrite, 1'b1); chk1("t2_lh_lo", IRLH, 1'b0);
    chk16("t2_addr_lo", MemAddr, 16'h0010);
    step();
    chk1("t2_wr_hi", IRWrite, 1'b1); chk1("t2_lh_hi", IRLH, 1'b1);
    chk16("t2_addr_hi", MemAddr, 16'h0011);
    step();
    chk1("t2_valid", InstrValid, 1'b1); chk16("t2_pc", PC, 16'h0012);
    step();
    chk1("t2_next_rd", MemRead, 1'b1); chk16("t2_next_addr", MemAddr, 16'h0012);
    Start = 1'b0;
    step(); step(); step();
    chk1("t2_idle", Busy, 1'b0); chk16("t2_pc_end", PC, 16'h0014);

    // Low byte delayed by three cycles
    Start = 1'b1; MemReady = 1'b0; step();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("t3_hold_rd", MemRead, 1'b1); chk1("t3_no_wr", IRWrite, 1'b0);
      chk16("t3_pc_hold", PC, 16'h0014);
      step();
    end
    MemReady = 1'b1; #1;
    chk1("t3_wr", IRWrite, 1'b1);
    step();
    chk16("t3_pc_lo", PC, 16'h0015); chk1("t3_lh", IRLH, 1'b1);
    step();
    chk1("t3_valid", InstrValid, 1'b1); chk16("t3_pc", PC, 16'h0016);
    step();

    // Timeout, then Start ignored until PCLoad clears the error
    Start = 1'b1; MemReady = 1'b0; step();
    Start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk1("t4_no_err", FetchError, 1'b0); chk1("t4_rd", MemRead, 1'b1);
      step();
    end
    chk1("t4_err", FetchError, 1'b1); chk1("t4_idle", Busy, 1'b0);
    chk16("t4_pc", PC, 16'h0016);
    Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("t4_start_ignored", Busy, 1'b0);
    end
    PCLoad = 1'b1; PCLoadValue = 16'h0100; step();
    PCLoad = 1'b0; Start = 1'b0;
    chk1("t4_err_clr", FetchError, 1'b0); chk16("t4_pc_load", PC, 16'h0100);

    // PC wraparound across 0xFFFF
    PCLoad = 1'b1; PCLoadValue = 16'hFFFF; step();
    PCLoad = 1'b0; Start = 1'b1; MemReady = 1'b1; step();
    Start = 1'b0;
    chk16("t5_addr_lo", MemAddr, 16'hFFFF); chk1("t5_wr_lo", IRWrite, 1'b1);
    step();
    chk16("t5_addr_hi", MemAddr, 16'h0000); chk1("t5_lh", IRLH, 1'b1);
    step();
    chk16("t5_pc", PC, 16'h0001); chk1("t5_valid", InstrValid, 1'b1);
    step();

    // Flush during the high byte read
    Start = 1'b1; MemReady = 1'b1; step(); step();
    PCLoad = 1'b1; PCLoadValue = 16'h0200; #1;
    chk1("t6_flush_no_wr", IRWrite, 1'b0);
    step();
    PCLoad = 1'b0; Start = 1'b0;
    chk16("t6_flush_pc", PC, 16'h0200); chk1("t6_flush_idle", Busy, 1'b0);
    step();
    chk1("t6_flush_no_valid", InstrValid, 1'b0);

    // Stall for four cycles in FETCH_L
    Start = 1'b1; MemReady = 1'b0; step();
    Start = 1'b0; Stall = 1'b1; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("t6_stall_rd", MemRead, 1'b0); chk1("t6_stall_wr", IRWrite, 1'b0);
      chk16("t6_stall_pc", PC, 16'h0200); chk1("t6_stall_busy", Busy, 1'b1);
      step();
    end
    Stall = 1'b0; #1;
    chk1("t6_resume_wr", IRWrite, 1'b1); chk16("t6_resume_addr", MemAddr, 16'h0200);
    step(); step();
    chk1("t6_valid", InstrValid, 1'b1); chk16("t6_pc", PC, 16'h0202);
    step();

    // Asynchronous reset while reading the high byte
    Start = 1'b1; MemReady = 1'b1; step(); step();
    MemReady = 1'b0; Start = 1'b0; #1;
    chk1("t1_pre_rd", MemRead, 1'b1);
    Reset = 1'b1; #1;
    chk1("t1_rd", MemRead, 1'b0); chk1("t1_busy", Busy, 1'b0);
    chk1("t1_lh", IRLH, 1'b0); chk16("t1_pc", PC, 16'h0000);
    step();
    Reset = 1'b0;

    // Randomized traffic with varying memory responsiveness
    for (int blk = 0; blk < 40; blk++) begin
      int unsigned rp;
      rp = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 90 : 40);
      for (int c = 0; c < 50; c++) begin
        Reset    = ($urandom_range(0, 199) == 0);
        Start    = ($urandom_range(0, 99) < 60);
        Stall    = ($urandom_range(0, 99) < 10);
        PCLoad   = ($urandom_range(0, 99) < 3);
        MemReady = ($urandom_range(0, 99) < rp);
        PCLoadValue = ($urandom_range(0, 3) == 0) ? (16'hFFFE + 16'($urandom_range(0, 1)))
                                                  : 16'($urandom);
        step();
      end
    end

    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; PCLoad = 1'b0; MemReady = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
